// File: rtl/nes_bus_pkg.sv
// Shared definitions for the NES CPU bus responder: region map, DMA states
// and the address decode used by both the CPU path and the OAM DMA source.
package nes_bus_pkg;

  localparam logic [15:0] RAM_END  = 16'h1FFF;
  localparam logic [15:0] IO_END   = 16'h401F;
  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] ROM_BASE = 16'h8000;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_ALIGN,
    DMA_ALIGN2,
    DMA_RD,
    DMA_WR
  } dma_state_t;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_IO,
    RGN_DMA,
    RGN_UNMAP,
    RGN_ROM
  } region_t;

  function automatic region_t decode_region(input logic [15:0] addr);
    region_t rgn;
    if (addr <= RAM_END) begin
      rgn = RGN_RAM;
    end else if (addr <= IO_END) begin
      rgn = (addr == DMA_REG) ? RGN_DMA : RGN_IO;
    end else if (addr >= ROM_BASE) begin
      rgn = RGN_ROM;
    end else begin
      rgn = RGN_UNMAP;
    end
    return rgn;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// $4014 OAM DMA engine: halts the CPU, then copies page {N,00..FF} to OAM,
// one read and one OAM write per byte.
//
// state  | meaning
// IDLE   | CPU owns the bus, rdy high
// ALIGN  | first halt cycle after the trigger
// ALIGN2 | extra halt cycle when the trigger landed on an odd cycle
// RD     | read source {page,cnt}; I/O sources take a second cycle
// WR     | present dma_buf to OAM, advance cnt
module oam_dma
  import nes_bus_pkg::*;
(
  input  logic        clk_ph2,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_page,
  input  logic        i_src_io,
  input  logic [7:0]  i_mem_data,
  input  logic [7:0]  i_io_data,
  output logic        o_active,
  output logic        o_rd_req,
  output logic        o_io_req,
  output logic [15:0] o_src_addr,
  output logic        o_oam_we,
  output logic [7:0]  o_oam_data
);

  dma_state_t r_state;
  dma_state_t w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] r_page;
  logic [7:0] r_buf;
  logic       r_parity;
  logic       r_par_trig;
  logic       r_io_wait;
  logic       w_latch;
  logic [7:0] w_byte;

  always_ff @(posedge clk_ph2) begin
    if (rst) begin
      r_state    <= DMA_IDLE;
      r_cnt      <= 8'h00;
      r_page     <= 8'h00;
      r_buf      <= 8'h00;
      r_parity   <= 1'b0;
      r_par_trig <= 1'b0;
      r_io_wait  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_parity <= ~r_parity;
      // parity is captured as it stood before the trigger edge
      if (r_state == DMA_IDLE && i_start) begin
        r_page     <= i_page;
        r_par_trig <= r_parity;
      end
      if (o_io_req) begin
        r_io_wait <= 1'b1;
      end
      if (w_latch) begin
        r_buf     <= w_byte;
        r_io_wait <= 1'b0;
      end
      if (r_state == DMA_WR) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_io_req    = 1'b0;
    w_latch     = 1'b0;
    w_byte      = i_src_io ? i_io_data : i_mem_data;
    case (r_state)
      DMA_IDLE:   if (i_start) w_state_nxt = DMA_ALIGN;
      DMA_ALIGN:  w_state_nxt = r_par_trig ? DMA_ALIGN2 : DMA_RD;
      DMA_ALIGN2: w_state_nxt = DMA_RD;
      DMA_RD: begin
        if (i_src_io && !r_io_wait) begin
          o_io_req = 1'b1;
        end else begin
          w_latch     = 1'b1;
          w_state_nxt = DMA_WR;
        end
      end
      DMA_WR:     w_state_nxt = (r_cnt == 8'hFF) ? DMA_IDLE : DMA_RD;
      default:    w_state_nxt = DMA_IDLE;
    endcase
  end

  assign o_active   = (r_state != DMA_IDLE);
  assign o_rd_req   = (r_state == DMA_RD);
  assign o_src_addr = {r_page, r_cnt};
  assign o_oam_we   = (r_state == DMA_WR);
  assign o_oam_data = r_buf;

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU-side bus responder: work RAM, PRG ROM, open-bus latch, I/O forwarding
// for $2000-$401F and the $4014 OAM DMA engine.
module cpu_bus_responder
  import nes_bus_pkg::*;
#(
  parameter int PRG_AW = 15,
  parameter int RAM_AW = 11
) (
  input  logic              clk_ph2,
  input  logic              rst,
  input  logic [15:0]       Addr_bus,
  input  logic              R_nW,
  input  logic [7:0]        Data_bus_out,
  output logic [7:0]        Data_bus_in,
  output logic              rdy,
  input  logic              prg_we,
  input  logic [PRG_AW-1:0] prg_addr,
  input  logic [7:0]        prg_data,
  output logic [15:0]       io_addr,
  output logic              io_rd,
  output logic              io_we,
  output logic [7:0]        io_wdata,
  input  logic [7:0]        io_rdata,
  output logic              oam_we,
  output logic [7:0]        oam_data
);

  logic [7:0] r_ram [2**RAM_AW];
  logic [7:0] r_rom [2**PRG_AW];
  logic [7:0] r_open_bus;
  logic       r_cpu_io_pend;

  logic        w_dma_active;
  logic        w_dma_rd;
  logic        w_dma_io_req;
  logic [15:0] w_dma_src;
  logic [15:0] w_rd_addr;
  region_t     w_region;
  logic [7:0]  w_mem_data;
  logic        w_cpu_rd;
  logic        w_cpu_wr;
  logic        w_dma_start;

  // the DMA source shares the CPU read path while the engine is reading
  assign w_rd_addr   = w_dma_rd ? w_dma_src : Addr_bus;
  assign w_region    = decode_region(w_rd_addr);
  assign w_cpu_rd    = !w_dma_active && R_nW;
  assign w_cpu_wr    = !w_dma_active && !R_nW;
  assign w_dma_start = w_cpu_wr && (w_region == RGN_DMA);
  assign rdy         = !w_dma_active;

  always_comb begin
    w_mem_data = r_open_bus;
    case (w_region)
      RGN_RAM: w_mem_data = r_ram[w_rd_addr[RAM_AW-1:0]];
      RGN_ROM: w_mem_data = r_rom[w_rd_addr[PRG_AW-1:0]];
      default: ;
    endcase
  end

  always_ff @(posedge clk_ph2) begin
    if (rst && prg_we) begin
      r_rom[prg_addr] <= prg_data;
    end
  end

  always_ff @(posedge clk_ph2) begin
    if (!rst && w_cpu_wr && w_region == RGN_RAM) begin
      r_ram[w_rd_addr[RAM_AW-1:0]] <= Data_bus_out;
    end
  end

  always_ff @(posedge clk_ph2) begin
    if (rst) begin
      Data_bus_in   <= 8'h00;
      r_open_bus    <= 8'h00;
      io_addr       <= 16'h0000;
      io_rd         <= 1'b0;
      io_we         <= 1'b0;
      io_wdata      <= 8'h00;
      r_cpu_io_pend <= 1'b0;
    end else begin
      io_rd         <= 1'b0;
      io_we         <= 1'b0;
      r_cpu_io_pend <= 1'b0;

      if (w_cpu_rd) begin
        case (w_region)
          RGN_RAM, RGN_ROM: begin
            Data_bus_in <= w_mem_data;
            r_open_bus  <= w_mem_data;
          end
          RGN_IO: begin
            io_rd         <= 1'b1;
            io_addr       <= Addr_bus;
            r_cpu_io_pend <= 1'b1;
          end
          default: Data_bus_in <= r_open_bus;
        endcase
      end

      if (w_cpu_wr) begin
        case (w_region)
          RGN_IO: begin
            io_we      <= 1'b1;
            io_addr    <= Addr_bus;
            io_wdata   <= Data_bus_out;
            r_open_bus <= Data_bus_out;
          end
          // ROM is read-only from the CPU side; the latch keeps its value
          RGN_ROM: Data_bus_in <= r_open_bus;
          default: r_open_bus  <= Data_bus_out;
        endcase
      end

      if (w_dma_io_req) begin
        io_rd   <= 1'b1;
        io_addr <= w_rd_addr;
      end

      // the second edge of a CPU I/O read wins over whatever the CPU does next
      if (r_cpu_io_pend) begin
        Data_bus_in <= io_rdata;
        r_open_bus  <= io_rdata;
      end
    end
  end

  oam_dma u_oam_dma (
    .clk_ph2    (clk_ph2),
    .rst        (rst),
    .i_start    (w_dma_start),
    .i_page     (Data_bus_out),
    .i_src_io   (w_region == RGN_IO),
    .i_mem_data (w_mem_data),
    .i_io_data  (io_rdata),
    .o_active   (w_dma_active),
    .o_rd_req   (w_dma_rd),
    .o_io_req   (w_dma_io_req),
    .o_src_addr (w_dma_src),
    .o_oam_we   (oam_we),
    .o_oam_data (oam_data)
  );

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: vector table for CPU accesses plus
// hand sequences for I/O timing, DMA halt length/data and reset mid-DMA.
module tb_cpu_bus_responder;

  localparam int PRG_AW = 14;
  localparam int RAM_AW = 11;

  logic              clk_ph2 = 1'b0;
  logic              rst;
  logic [15:0]       Addr_bus;
  logic              R_nW;
  logic [7:0]        Data_bus_out;
  logic [7:0]        Data_bus_in;
  logic              rdy;
  logic              prg_we;
  logic [PRG_AW-1:0] prg_addr;
  logic [7:0]        prg_data;
  logic [15:0]       io_addr;
  logic              io_rd;
  logic              io_we;
  logic [7:0]        io_wdata;
  logic [7:0]        io_rdata;
  logic              oam_we;
  logic [7:0]        oam_data;

  int n_cmp  = 0;
  int n_fail = 0;
  logic m_par = 1'b0;

  always #5 clk_ph2 = ~clk_ph2;

  // I/O device model: returns a byte derived from the forwarded address
  assign io_rdata = io_addr[7:0] ^ 8'h3C;

  always @(posedge clk_ph2) m_par <= rst ? 1'b0 : ~m_par;

  cpu_bus_responder #(.PRG_AW(PRG_AW), .RAM_AW(RAM_AW)) dut (
    .clk_ph2      (clk_ph2),
    .rst          (rst),
    .Addr_bus     (Addr_bus),
    .R_nW         (R_nW),
    .Data_bus_out (Data_bus_out),
    .Data_bus_in  (Data_bus_in),
    .rdy          (rdy),
    .prg_we       (prg_we),
    .prg_addr     (prg_addr),
    .prg_data     (prg_data),
    .io_addr      (io_addr),
    .io_rd        (io_rd),
    .io_we        (io_we),
    .io_wdata     (io_wdata),
    .io_rdata     (io_rdata),
    .oam_we       (oam_we),
    .oam_data     (oam_data)
  );

  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  wdata;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [15:0] a, input logic rnw, input logic [7:0] wd);
    Addr_bus     = a;
    R_nW         = rnw;
    Data_bus_out = wd;
    @(posedge clk_ph2);
    #1;
  endtask

  task automatic run_dma(input logic [7:0] page, input logic [7:0] xorv, input int extra,
                         input string tag, output logic p_used);
    int   halt, pulses, bad, consec, exp_halt;
    logic prev_we, done;
    logic [7:0] first_d, last_d, exp_d;
    p_used  = m_par;
    halt    = 0; pulses = 0; bad = 0; consec = 0;
    prev_we = 1'b0; done = 1'b0;
    first_d = 8'h00; last_d = 8'h00;
    cyc(16'h4014, 1'b0, page);
    // keep hammering $4014 for a few cycles; the engine must ignore it
    Data_bus_out = page ^ 8'h01;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_ph2);
      if (k == 5) begin
        Addr_bus = 16'h0000;
        R_nW     = 1'b1;
      end
      if (rdy) begin
        done = 1'b1;
        break;
      end
      halt++;
      if (oam_we) begin
        exp_d = 8'(pulses) ^ xorv;
        if (oam_data !== exp_d) bad++;
        if (pulses == 0) first_d = oam_data;
        last_d = oam_data;
        pulses++;
      end
      if (prev_we && oam_we) consec++;
      prev_we = oam_we;
    end
    exp_halt = 1 + int'(p_used) + 256 * (2 + extra);
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: rdy still low after %0d clocks, expected %0d", tag, halt, exp_halt);
    end
    check({tag, "_halt"}, 16'(halt), 16'(exp_halt));
    check({tag, "_pulses"}, 16'(pulses), 16'd256);
    check({tag, "_data_errs"}, 16'(bad), 16'd0);
    check({tag, "_consec_we"}, 16'(consec), 16'd0);
    check({tag, "_first"}, {8'h00, first_d}, {8'h00, xorv});
    check({tag, "_last"}, {8'h00, last_d}, {8'h00, 8'hFF ^ xorv});
    Addr_bus = 16'h0000;
    R_nW     = 1'b1;
    @(posedge clk_ph2);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p1, p2, hit;
    int   seen;

    vecs[0]  = '{16'h0013, 1'b0, 8'h5A, 1'b0, 8'h00};
    vecs[1]  = '{16'h0813, 1'b1, 8'h00, 1'b1, 8'h5A};
    vecs[2]  = '{16'h1013, 1'b1, 8'h00, 1'b1, 8'h5A};
    vecs[3]  = '{16'h1813, 1'b1, 8'h00, 1'b1, 8'h5A};
    vecs[4]  = '{16'hBFFC, 1'b1, 8'h00, 1'b1, 8'h4C};
    vecs[5]  = '{16'hFFFC, 1'b1, 8'h00, 1'b1, 8'h4C};
    vecs[6]  = '{16'hFFFC, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[7]  = '{16'h6000, 1'b1, 8'h00, 1'b1, 8'h4C};
    vecs[8]  = '{16'hFFFC, 1'b1, 8'h00, 1'b1, 8'h4C};
    vecs[9]  = '{16'h0000, 1'b0, 8'h77, 1'b0, 8'h00};
    vecs[10] = '{16'h0000, 1'b1, 8'h00, 1'b1, 8'h77};
    vecs[11] = '{16'h5000, 1'b1, 8'h00, 1'b1, 8'h77};
    vecs[12] = '{16'h4014, 1'b1, 8'h00, 1'b1, 8'h77};
    vecs[13] = '{16'h0001, 1'b0, 8'hC3, 1'b0, 8'h00};
    vecs[14] = '{16'h0001, 1'b1, 8'h00, 1'b1, 8'hC3};
    vecs[15] = '{16'h4020, 1'b1, 8'h00, 1'b1, 8'hC3};

    rst = 1'b1; prg_we = 1'b0; prg_addr = '0; prg_data = 8'h00;
    Addr_bus = 16'h0000; R_nW = 1'b1; Data_bus_out = 8'h00;
    @(posedge clk_ph2);
    #1;
    // ROM image for $FF00-$FFFF (index $3F00-$3FFF): low byte ^ $B0, so $3FFC = $4C
    for (int i = 0; i < 256; i++) begin
      prg_we   = 1'b1;
      prg_addr = 14'h3F00 + 14'(i);
      prg_data = 8'(i) ^ 8'hB0;
      @(posedge clk_ph2);
      #1;
    end
    prg_we = 1'b0;
    @(posedge clk_ph2);
    #1;
    check("rst_data_bus_in", {8'h00, Data_bus_in}, 16'h0000);
    check("rst_rdy", {15'h0, rdy}, 16'h0001);
    check("rst_io_rd", {15'h0, io_rd}, 16'h0000);
    check("rst_io_we", {15'h0, io_we}, 16'h0000);
    check("rst_oam_we", {15'h0, oam_we}, 16'h0000);
    check("rst_io_addr", io_addr, 16'h0000);
    check("rst_io_wdata", {8'h00, io_wdata}, 16'h0000);
    check("rst_oam_data", {8'h00, oam_data}, 16'h0000);
    rst = 1'b0;

    // a load strobe outside reset must not reach the ROM
    prg_we = 1'b1; prg_addr = 14'h3FFC; prg_data = 8'hEE;
    cyc(16'h0000, 1'b1, 8'h00);
    prg_we = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].addr, vecs[i].rnw, vecs[i].wdata);
      if (vecs[i].chk) check($sformatf("vec%0d_rd_%h", i, vecs[i].addr),
                             {8'h00, Data_bus_in}, {8'h00, vecs[i].exp});
    end

    cyc(16'h2006, 1'b0, 8'h12);
    check("io_wr_we", {15'h0, io_we}, 16'h0001);
    check("io_wr_addr", io_addr, 16'h2006);
    check("io_wr_data", {8'h00, io_wdata}, 16'h0012);
    cyc(16'h0000, 1'b1, 8'h00);
    check("io_wr_we_drop", {15'h0, io_we}, 16'h0000);

    cyc(16'h2002, 1'b1, 8'h00);
    check("io_rd_strobe", {15'h0, io_rd}, 16'h0001);
    check("io_rd_addr", io_addr, 16'h2002);
    cyc(16'h6000, 1'b1, 8'h00);
    check("io_rd_strobe_drop", {15'h0, io_rd}, 16'h0000);
    check("io_rd_data", {8'h00, Data_bus_in}, 16'h003E);
    cyc(16'h5000, 1'b1, 8'h00);
    check("io_rd_openbus", {8'h00, Data_bus_in}, 16'h003E);

    for (int i = 0; i < 256; i++) cyc(16'h0200 + 16'(i), 1'b0, 8'(i) ^ 8'hA5);

    run_dma(8'h02, 8'hA5, 0, "dma_a", p1);
    if (m_par == p1) cyc(16'h0000, 1'b1, 8'h00);
    run_dma(8'h02, 8'hA5, 0, "dma_b", p2);
    check("dma_parity_cover", {15'h0, p1 ^ p2}, 16'h0001);

    run_dma(8'hFF, 8'hB0, 0, "dma_rom", p1);
    run_dma(8'h20, 8'h3C, 1, "dma_io", p1);

    // reset while the 100th OAM pulse is on the bus
    cyc(16'h4014, 1'b0, 8'h02);
    Addr_bus = 16'h0000; R_nW = 1'b1;
    seen = 0; hit = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_ph2);
      if (oam_we) seen++;
      if (seen == 100) begin
        hit = 1'b1;
        rst = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL abort_reach: saw %0d pulses, expected 100", seen);
    end
    @(posedge clk_ph2);
    #1;
    check("abort_rdy", {15'h0, rdy}, 16'h0001);
    check("abort_oam_we", {15'h0, oam_we}, 16'h0000);
    rst = 1'b0;
    cyc(16'h0000, 1'b1, 8'h00);
    check("abort_still_idle", {15'h0, rdy}, 16'h0001);
    run_dma(8'h02, 8'hA5, 0, "dma_restart", p1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
